uart_tx_sched: RTL



---
 rtl/uart_tx_sched_pkg.sv | 19 +
 rtl/uart_tx_sched_rr_arbiter.sv | 33 +++
 rtl/uart_tx_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the round-robin UART transmit scheduler.
package uart_tx_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } sched_state_e;

   localparam int DEFAULT_GAP_CYCLES     = 16;
   localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

   // Width of an index/counter able to hold values 0..n-1, never narrower than 1 bit.
   function automatic int gnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward from ptr+1 (mod NREQ).
module rr_arbiter
   import uart_tx_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int GNT_W = gnt_w(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [GNT_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt_onehot,
   output logic [GNT_W-1:0] gnt_idx,
   output logic             gnt_any
);

   logic [GNT_W-1:0] cand;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      gnt_any    = 1'b0;
      cand       = '0;
      // Offset NREQ wraps back to ptr itself, so the last owner is considered last.
      for (int k = 1; k <= NREQ; k++) begin
         cand = GNT_W'((int'(ptr) + k) % NREQ);
         if (!gnt_any && req[cand]) begin
            gnt_onehot[cand] = 1'b1;
            gnt_idx          = cand;
            gnt_any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ requesters with round-robin grants and a guard gap.
// Define UART_TX_SCHED_TIMEOUT_EN to add the WAIT-state watchdog and its timeout_err output.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int NREQ           = 4,
   parameter int DATA_W         = 8,
   parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic [DATA_W-1:0]        tx_data,
   output logic                     start_tx,
   input  logic                     tx_done,
   input  logic                     cts_n,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     sent_pulse
`ifdef UART_TX_SCHED_TIMEOUT_EN
   ,
   output logic                     timeout_err
`endif
);

   localparam int GNT_W = gnt_w(NREQ);
   localparam int GAP_W = gnt_w(GAP_CYCLES + 1);

   if (NREQ < 2 || NREQ > 8 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("uart_tx_sched: unsupported parameter set");
   end

   sched_state_e      state_q, state_d;
   logic [GNT_W-1:0]  rr_ptr;
   logic [GAP_W-1:0]  gap_cnt;
   logic [NREQ-1:0]   gnt_onehot;
   logic [GNT_W-1:0]  gnt_idx;
   logic              gnt_any;
   logic              grant_en;
   logic              do_grant;
   logic              wd_expire;

   rr_arbiter #(
      .NREQ  (NREQ),
      .GNT_W (GNT_W)
   ) u_arb (
      .req        (req_valid),
      .ptr        (rr_ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .gnt_any    (gnt_any)
   );

   // Keeping req_ready low while reset is held makes every output read 0 in reset.
   assign grant_en  = reset_n && (state_q == IDLE) && !cts_n;
   assign req_ready = grant_en ? gnt_onehot : '0;
   assign do_grant  = grant_en && gnt_any;
   assign start_tx  = (state_q == START);
   assign busy      = (state_q != IDLE);

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam int WD_W = gnt_w(TIMEOUT_CYCLES);

   logic [WD_W-1:0] wd_cnt;

   // tx_done arriving on the final watchdog cycle still counts as a normal completion.
   assign wd_expire = (state_q == WAIT) && !tx_done && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= wd_expire;
         if (state_q == START) begin
            wd_cnt <= '0;
         end else if (state_q == WAIT) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end
      end
   end
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (do_grant) state_d = START;
         START:   state_d = WAIT;
         WAIT:    if (tx_done || wd_expire) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
         GAP:     if (gap_cnt == GAP_W'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_data    <= '0;
         grant_id   <= '0;
         rr_ptr     <= GNT_W'(NREQ - 1);
         gap_cnt    <= '0;
         sent_pulse <= 1'b0;
      end else begin
         sent_pulse <= (state_q == WAIT) && tx_done;
         if (do_grant) begin
            tx_data  <= req_data[gnt_idx*DATA_W +: DATA_W];
            grant_id <= gnt_idx;
            rr_ptr   <= gnt_idx;
         end
         // The gap counter runs GAP_CYCLES..1, one value per cycle spent in GAP.
         if (state_q == WAIT && state_d == GAP) begin
            gap_cnt <= GAP_W'(GAP_CYCLES);
         end else if (state_q == GAP) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end
      end
   end

endmodule
